register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is writable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_addr1, rd_addr2  input  ADDR_W  read port addresses.
REQ-007 rd_data1, rd_data2  output  DATA_W  combinational read data.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 wr_ready  output  1  write accepted this cycle when wr_en && wr_ready.
REQ-012 clear_req  input  1  one-cycle request to zero the whole bank.
REQ-013 busy  output  1  initialisation or clear sweep in progress.

Function
REQ-014 The FSM SHALL have states INIT, IDLE and CLEAR.
REQ-015 The sweep counter SHALL reset to 0 and increment by 1 per cycle in INIT and CLEAR, writing 0 to entry[counter].
REQ-016 After writing entry DEPTH-1, the FSM SHALL go to IDLE and clear the counter to 0, so one sweep lasts DEPTH cycles.
REQ-017 In IDLE, clear_req=1 SHALL move the FSM to CLEAR on the next edge.
REQ-018 clear_req SHALL be ignored in INIT and CLEAR, and the counter SHALL not restart.
REQ-019 busy SHALL be 1 exactly while the state is INIT or CLEAR.
REQ-020 wr_ready SHALL be 1 exactly when state = IDLE and clear_req = 0; clear therefore takes priority over a simultaneous write.
REQ-021 An accepted write SHALL update entry[wr_addr] at the next edge, except when ZERO_REG=1 and wr_addr=0.
REQ-022 wr_en while wr_ready=0 SHALL be dropped, with no effect on state.
REQ-023 Reads SHALL be combinational: rd_dataN = entry[rd_addrN].
REQ-024 Write bypass: if a write is accepted this cycle and wr_addr = rd_addrN, rd_dataN SHALL equal wr_data in that same cycle. The zero-register rule takes precedence.
REQ-025 With ZERO_REG=1, rd_addrN = 0 SHALL always return 0.
REQ-026 While busy=1, rd_data1 and rd_data2 SHALL return 0.
REQ-027 Both read ports SHALL be independent and may address the same register.

Reset
REQ-028 Asserting reset SHALL immediately force state = INIT, counter = 0, busy = 1, wr_ready = 0 and rd_data1 = rd_data2 = 0.
REQ-029 Array contents SHALL NOT be reset asynchronously; the INIT sweep after reset release zeroes them in DEPTH cycles.
REQ-030 Reset asserted mid-sweep or mid-write SHALL abort the operation; the sweep restarts from entry 0 after release.

Structure
REQ-031 Package register_bank_pkg SHALL hold the state enum (INIT, IDLE, CLEAR) and the default parameter constants.
REQ-032 The FSM and counter SHALL be a sub-module register_bank_sweep_ctrl, outputting busy, sweep_we and sweep_addr; the storage array and read/bypass logic stay in the top level.
REQ-033 The storage SHALL be a single DEPTH x DATA_W array with one write port muxed between the sweep and the user write.

Verification
REQ-034 Reset pulse, then release -> busy=1 for exactly 32 cycles and wr_ready=0 throughout; afterwards all 32 entries read 0.
REQ-035 Write 0xDEADBEEF to r5 with rd_addr1=5 in the same cycle -> rd_data1=0xDEADBEEF in that cycle (bypass) and on every later cycle.
REQ-036 ZERO_REG=1: write 0x12345678 to r0 -> rd_data1 at r0 stays 0. ZERO_REG=0: the same write reads back 0x12345678.
REQ-037 In IDLE, clear_req and wr_en (r7 <= 0xA5A5A5A5) in the same cycle -> wr_ready=0, the write is dropped, busy=1 for 32 cycles, then r7=0.
REQ-038 Reset asserted at sweep count 10 -> busy stays 1 and the sweep restarts at 0, completing 32 cycles after release.
REQ-039 DATA_W=16, ADDR_W=3 -> sweep of 8 cycles; both ports reading r3 after writing 0xBEEF to r3 return 0xBEEF.

Source files
------------

// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared state encoding and default parameters for the register bank
package register_bank_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_DEF = 1;

endpackage

// File: rtl/register_bank_sweep_ctrl.sv
// rtl/register_bank_sweep_ctrl.sv - INIT/IDLE/CLEAR sequencer that walks every entry writing zero
module register_bank_sweep_ctrl
    import register_bank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // The all-ones count is entry DEPTH-1, so a sweep spans exactly DEPTH cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        busy        = 1'b0;
        sweep_we    = 1'b0;
        sweep_addr  = r_count;
        case (r_state)
            INIT, CLEAR: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (r_count == '1) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_count_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - two-read/one-write register bank with init/clear sweep and write bypass
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear_req,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_accept;
    logic              w_wr_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;

    register_bank_sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_sweep_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (w_busy),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    assign busy        = w_busy;
    assign wr_ready    = !w_busy && !clear_req;
    assign w_wr_accept = wr_en && wr_ready;
    assign w_wr_commit = w_wr_accept && !((ZERO_REG != 0) && (wr_addr == '0));

    // Single write port: the sweep owns it while busy, user writes only in IDLE.
    assign w_mem_we   = w_sweep_we || w_wr_commit;
    assign w_mem_addr = w_sweep_we ? w_sweep_addr : wr_addr;
    assign w_mem_data = w_sweep_we ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Read priority: busy blanking, then hard-wired zero, then bypass, then storage.
    always_comb begin
        rd_data1 = r_mem[rd_addr1];
        if (w_busy) begin
            rd_data1 = '0;
        end else if ((ZERO_REG != 0) && (rd_addr1 == '0)) begin
            rd_data1 = '0;
        end else if (w_wr_accept && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
    end

    always_comb begin
        rd_data2 = r_mem[rd_addr2];
        if (w_busy) begin
            rd_data2 = '0;
        end else if ((ZERO_REG != 0) && (rd_addr2 == '0)) begin
            rd_data2 = '0;
        end else if (w_wr_accept && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - scoreboard bench for register_bank (default build and 16x8 ZERO_REG=0 build)
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] wr_data;

    logic [31:0] a_rd_data1, a_rd_data2;
    logic        a_wr_ready, a_busy;
    logic [15:0] b_rd_data1, b_rd_data2;
    logic        b_wr_ready, b_busy;

    always #5 clk = ~clk;

    register_bank u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (a_rd_data1),
        .rd_data2  (a_rd_data2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (a_wr_ready),
        .clear_req (clear_req),
        .busy      (a_busy)
    );

    register_bank #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .ZERO_REG (0)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .rd_addr1  (rd_addr1[2:0]),
        .rd_addr2  (rd_addr2[2:0]),
        .rd_data1  (b_rd_data1),
        .rd_data2  (b_rd_data2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr[2:0]),
        .wr_data   (wr_data[15:0]),
        .wr_ready  (b_wr_ready),
        .clear_req (clear_req),
        .busy      (b_busy)
    );

    typedef struct {
        int          cyc;
        logic        busy_a;
        logic        rdy_a;
        logic [31:0] rd1_a;
        logic [31:0] rd2_a;
        logic        busy_b;
        logic        rdy_b;
        logic [15:0] rd1_b;
        logic [15:0] rd2_b;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cycle_no = 0;

    // Reference model: bank 0 = 32x32 with hard zero r0, bank 1 = 8x16 fully writable.
    logic [31:0] mem_m [2][32];
    int          left_m [2];

    function automatic int dep(input int b);
        return (b == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] exp_rd(input int b, input bit bsy, input bit acc,
                                           input int wa, input int ra, input logic [31:0] wd);
        int          m;
        logic [31:0] d;
        m = dep(b) - 1;
        d = (b == 0) ? wd : (wd & 32'h0000_FFFF);
        if (bsy) return 32'h0;
        if (b == 0 && (ra & m) == 0) return 32'h0;
        if (acc && (wa & m) == (ra & m)) return d;
        return mem_m[b][ra & m];
    endfunction

    function automatic void step(input int b, input bit rst, input bit clr, input bit we,
                                 input int wa, input logic [31:0] wd);
        int m;
        m = dep(b) - 1;
        if (rst || (left_m[b] == 0 && clr)) begin
            left_m[b] = dep(b);
            for (int i = 0; i < 32; i++) mem_m[b][i] = 32'h0;
        end else if (left_m[b] > 0) begin
            left_m[b] = left_m[b] - 1;
        end else if (we) begin
            if (!(b == 0 && (wa & m) == 0))
                mem_m[b][wa & m] = (b == 0) ? wd : (wd & 32'h0000_FFFF);
        end
    endfunction

    task automatic drive_cycle(input bit rst, input bit clr, input bit we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        exp_t        e;
        logic [31:0] t;
        reset     = rst;
        clear_req = clr;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr1  = r1;
        rd_addr2  = r2;
        e.cyc    = cycle_no;
        e.busy_a = rst || left_m[0] > 0;
        e.rdy_a  = !e.busy_a && !clr;
        e.rd1_a  = exp_rd(0, e.busy_a, e.rdy_a && we, int'(wa), int'(r1), wd);
        e.rd2_a  = exp_rd(0, e.busy_a, e.rdy_a && we, int'(wa), int'(r2), wd);
        e.busy_b = rst || left_m[1] > 0;
        e.rdy_b  = !e.busy_b && !clr;
        t        = exp_rd(1, e.busy_b, e.rdy_b && we, int'(wa), int'(r1), wd);
        e.rd1_b  = t[15:0];
        t        = exp_rd(1, e.busy_b, e.rdy_b && we, int'(wa), int'(r2), wd);
        e.rd2_b  = t[15:0];
        sbq.push_back(e);
        @(posedge clk);
        step(0, rst, clr, we, int'(wa), wd);
        step(1, rst, clr, we, int'(wa), wd);
        cycle_no++;
        #1;
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("busy_a",  mon_e.cyc, {31'h0, a_busy},     {31'h0, mon_e.busy_a});
            chk("ready_a", mon_e.cyc, {31'h0, a_wr_ready}, {31'h0, mon_e.rdy_a});
            chk("rd1_a",   mon_e.cyc, a_rd_data1,          mon_e.rd1_a);
            chk("rd2_a",   mon_e.cyc, a_rd_data2,          mon_e.rd2_a);
            chk("busy_b",  mon_e.cyc, {31'h0, b_busy},     {31'h0, mon_e.busy_b});
            chk("ready_b", mon_e.cyc, {31'h0, b_wr_ready}, {31'h0, mon_e.rdy_b});
            chk("rd1_b",   mon_e.cyc, {16'h0, b_rd_data1}, {16'h0, mon_e.rd1_b});
            chk("rd2_b",   mon_e.cyc, {16'h0, b_rd_data2}, {16'h0, mon_e.rd2_b});
        end
    end

    function automatic logic [4:0] ra5();
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        left_m[0] = 32;
        left_m[1] = 8;
        for (int i = 0; i < 32; i++) begin
            mem_m[0][i] = 32'h0;
            mem_m[1][i] = 32'h0;
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1, ra5(), $urandom, ra5(), ra5());
        // Reset again when the default bank's sweep counter has reached 10.
        for (int i = 0; i < 10; i++) drive_cycle(0, $urandom_range(0, 1), 1, ra5(), $urandom, ra5(), ra5());
        for (int i = 0; i < 2; i++) drive_cycle(1, 0, 0, 5'd0, 32'h0, ra5(), ra5());
        for (int i = 0; i < 34; i++) drive_cycle(0, 0, $urandom_range(0, 1), ra5(), $urandom, ra5(), ra5());
        for (int i = 0; i < 16; i++) drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'(2 * i), 5'(2 * i + 1));

        drive_cycle(0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        drive_cycle(0, 0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd5);
        drive_cycle(0, 0, 1, 5'd3, 32'h0000_BEEF, 5'd3, 5'd3);
        for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'd3, 5'd3);

        drive_cycle(0, 0, 1, 5'd7, 32'h1111_1111, 5'd2, 5'd4);
        drive_cycle(0, 1, 1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7);
        for (int i = 0; i < 32; i++) drive_cycle(0, $urandom_range(0, 1), 1, 5'd7, $urandom, 5'd7, ra5());
        for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd5);

        for (int i = 0; i < 500; i++) begin
            drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                        $urandom_range(0, 1) == 1, ra5(), $urandom, ra5(), ra5());
        end

        drive_cycle(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
